scalar_mul_sequencer: RTL and testbench
=======================================

// Module: scalar_mul_sequencer
// PURPOSE
//  Left-to-right double-and-add scheduler for the scalar multiplication datapath.
//  Latches the private key and walks it from MSB to LSB.
//  Issues LOAD/DOUBLE/ADD commands to the point add/double engine and waits for
//  that engine's completion interrupts. Guards every command with a watchdog.
//  Replaces the ad-hoc bit stepping inside scalar_multiplication_module.
// PARAMETERS
//  KEY_W        576   scalar width in bits (private_key width)
//  IDX_W        10    width of bit index; must satisfy 2**IDX_W >= KEY_W
//  TIMEOUT_CYC  4096  maximum cycles allowed from cmd_valid to the matching interrupt
// PORTS
//  clk                      in   1      system clock; all state changes on posedge
//  rst_n                    in   1      asynchronous active-low reset
//  start                    in   1      1-cycle request; ignored while busy=1
//  abort                    in   1      cancel the current operation
//  scalar                   in   KEY_W  private key; sampled in the start cycle
//  interupt_point_double    in   1      1-cycle pulse: DOUBLE finished
//  interupt_point_addition  in   1      1-cycle pulse: ADD or LOAD finished
//  cmd_valid                out  1      1-cycle pulse that qualifies command_add_double
//  command_add_double       out  2      01=DOUBLE Q, 10=ADD Q+=P, 11=LOAD Q=P, 00=none
//  add_dummy                out  1      qualifies ADD: result goes to scratch, not to Q
//  busy                     out  1      high from the cycle after start until done/abort/err
//  done                     out  1      1-cycle pulse on successful completion
//  zero_result              out  1      scalar was 0; result is the point at infinity
//  err                      out  1      watchdog expired; sticky until the next accepted start
//  bit_index                out  IDX_W  bit currently being processed
//  op_count                 out  16     commands issued in this operation
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; bit_index=KEY_W-1.
//  States and transitions:
//   IDLE   -> SCAN when start=1. In that cycle: latch scalar; idx=KEY_W-1;
//             clear zero_result, err and op_count.
//   SCAN   Tests scalar_r[idx], one bit per cycle.
//          Bit set: -> LOAD.
//          Bit clear and idx>0: idx-1, stay in SCAN.
//          Bit clear and idx=0: zero_result=1, done pulse, -> IDLE. No command is issued.
//   LOAD   Issue 11. -> WAIT_A.
//   WAIT_A On interupt_point_addition: -> NEXT.
//   NEXT   idx=0: done pulse, -> IDLE.
//          Otherwise: idx-1, -> DBL.
//   DBL    Issue 01. -> WAIT_D.
//   WAIT_D On interupt_point_double:
//          scalar_r[idx]=1: -> ADD.
//          Otherwise: -> NEXT.
//   ADD    Issue 10. -> WAIT_A.
//  Command issue:
//   - cmd_valid is high for exactly 1 cycle per command.
//   - command_add_double holds its value until the next issue.
//   - op_count increments on each issue and saturates at 16'hFFFF.
//  Interrupts:
//   - An interrupt of the wrong type, or one arriving outside a WAIT state, is ignored.
//   - If both interrupts arrive together, only the expected one is used.
//  Watchdog:
//   - Counter cleared on each issue.
//   - If it reaches TIMEOUT_CYC while in a WAIT state: err=1, busy=0, -> IDLE, no done pulse.
//  abort:
//   - Has priority over all other events in any non-IDLE state: -> IDLE next cycle.
//   - busy=0, no done pulse, err unchanged.
//   - A late interrupt arriving after abort is ignored.
//   - abort in IDLE has no effect.
//  start and abort together in IDLE: start wins.
//  Async reset mid-operation returns all outputs to reset values immediately.
//  busy rises the cycle after start and falls in the same cycle that done pulses.
// CONFIGURATION
//  SCALAR_MUL_CONST_TIME_EN
//   Defined:
//    - WAIT_D always goes to ADD.
//    - add_dummy = ~scalar_r[idx] at issue, so every bit below the MSB costs DBL+ADD.
//    - SCAN always runs KEY_W cycles (the leading one is recorded; scanning continues).
//   Undefined:
//    - ADD is issued only for set bits; add_dummy is tied to 0.
//    - SCAN stops at the first set bit.
// TESTING
//  1. scalar=1 -> SCAN runs KEY_W cycles; LOAD; done; op_count=1; zero_result=0.
//  2. scalar=6 -> commands LOAD, DBL, ADD, DBL; done; op_count=4; bit_index ends at 0.
//  3. scalar=0 -> no cmd_valid; done after KEY_W scan cycles; zero_result=1.
//  4. TIMEOUT_CYC=16, scalar=3, DBL interrupt withheld -> err=1 sixteen cycles after
//     the DBL issue; busy=0; no done; next start clears err.
//  5. scalar=5, abort asserted during the first WAIT_D, interrupt sent 2 cycles later
//     -> IDLE; no further cmd_valid; done never pulses.
//  6. CONST_TIME_EN, scalar=4 -> LOAD, DBL, ADD(dummy=1), DBL, ADD(dummy=1);
//     op_count=5; SCAN=KEY_W cycles.

Source files
------------

// File: rtl/scalar_mul_sequencer.sv
// scalar_mul_sequencer
//   Left-to-right double-and-add scheduler for the scalar multiplication
//   datapath. Latches the private key on start and walks it from MSB to LSB,
//   issuing LOAD / DOUBLE / ADD commands to the point add/double engine and
//   waiting for that engine's completion interrupts. A watchdog guards every
//   command.
//
//   Optional feature: define SCALAR_MUL_CONST_TIME_EN for a constant-time
//   schedule. In that mode every bit below the MSB costs DBL+ADD, with
//   add_dummy marking ADDs whose result goes to scratch. The scan also always
//   covers all KEY_W bits.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    1-cycle request, ignored while busy
//   abort                    cancel the current operation (no effect in IDLE)
//   scalar[KEY_W]            private key, sampled in the start cycle
//   interupt_point_double    DOUBLE finished (1-cycle pulse)
//   interupt_point_addition  ADD or LOAD finished (1-cycle pulse)
//   cmd_valid                1-cycle pulse qualifying command_add_double
//   command_add_double[2]    01=DOUBLE, 10=ADD, 11=LOAD; holds until next issue
//   add_dummy                ADD result goes to scratch (constant-time mode only)
//   busy                     operation in progress
//   done                     1-cycle pulse on successful completion
//   zero_result              scalar was zero
//   err                      watchdog expired; sticky until next accepted start
//   bit_index[IDX_W]         bit currently being processed
//   op_count[16]             commands issued in this operation (saturating)
module scalar_mul_sequencer #(
    parameter int KEY_W       = 576,
    parameter int IDX_W       = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] scalar,
    input  logic             interupt_point_double,
    input  logic             interupt_point_addition,
    output logic             cmd_valid,
    output logic [1:0]       command_add_double,
    output logic             add_dummy,
    output logic             busy,
    output logic             done,
    output logic             zero_result,
    output logic             err,
    output logic [IDX_W-1:0] bit_index,
    output logic [15:0]      op_count
);
    localparam int              WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KEY_W - 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       CMD_DBL  = 2'b01;
    localparam logic [1:0]       CMD_ADD  = 2'b10;
    localparam logic [1:0]       CMD_LOAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_LOAD, S_WAIT_A, S_NEXT, S_DBL, S_WAIT_D, S_ADD
    } state_t;

    state_t           state, state_nx;
    logic [KEY_W-1:0] scalar_r;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [WD_W-1:0]  wd;
    logic             accept, cur_bit, issue, finish_ok, finish_zero, timeout;
    logic [1:0]       issue_cmd;
`ifdef SCALAR_MUL_CONST_TIME_EN
    logic             issue_dummy, found, found_nx;
    logic [IDX_W-1:0] lead, lead_nx;
`endif

    // Engine handshake: cmd_valid is a single-cycle pulse; the engine answers
    // each command with exactly one interrupt pulse of the matching type
    // (double for DBL, addition for ADD/LOAD). The interrupt is only consumed
    // in the matching WAIT state, from the cmd_valid cycle onward; anything
    // else is dropped. The watchdog allows TIMEOUT_CYC cycles, counted from
    // the cmd_valid cycle, for the answer to arrive.
    assign accept    = (state == S_IDLE) && start;
    assign cur_bit   = scalar_r[idx];
    assign busy      = (state != S_IDLE);
    assign bit_index = idx;

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        issue       = 1'b0;
        issue_cmd   = CMD_LOAD;
        finish_ok   = 1'b0;
        finish_zero = 1'b0;
        timeout     = 1'b0;
`ifdef SCALAR_MUL_CONST_TIME_EN
        issue_dummy = 1'b0;
        found_nx    = found;
        lead_nx     = lead;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SCAN;
                    idx_nx   = IDX_TOP;
`ifdef SCALAR_MUL_CONST_TIME_EN
                    found_nx = 1'b0;
`endif
                end
            end
            S_SCAN: begin
`ifdef SCALAR_MUL_CONST_TIME_EN
                // Scan every bit; remember the leading one, resume from it.
                if (cur_bit && !found) begin
                    found_nx = 1'b1;
                    lead_nx  = idx;
                end
                if (idx != '0) begin
                    idx_nx = idx - IDX_W'(1);
                end else if (found || cur_bit) begin
                    state_nx = S_LOAD;
                    idx_nx   = found ? lead : idx;
                end else begin
                    finish_zero = 1'b1;
                    state_nx    = S_IDLE;
                end
`else
                if (cur_bit) begin
                    state_nx = S_LOAD;
                end else if (idx != '0) begin
                    idx_nx = idx - IDX_W'(1);
                end else begin
                    finish_zero = 1'b1;
                    state_nx    = S_IDLE;
                end
`endif
            end
            S_LOAD: begin
                issue     = 1'b1;
                issue_cmd = CMD_LOAD;
                state_nx  = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (interupt_point_addition) begin
                    state_nx = S_NEXT;
                end else if (wd == WD_LAST) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_NEXT: begin
                if (idx == '0) begin
                    finish_ok = 1'b1;
                    state_nx  = S_IDLE;
                end else begin
                    idx_nx   = idx - IDX_W'(1);
                    state_nx = S_DBL;
                end
            end
            S_DBL: begin
                issue     = 1'b1;
                issue_cmd = CMD_DBL;
                state_nx  = S_WAIT_D;
            end
            S_WAIT_D: begin
                if (interupt_point_double) begin
`ifdef SCALAR_MUL_CONST_TIME_EN
                    state_nx = S_ADD;
`else
                    state_nx = cur_bit ? S_ADD : S_NEXT;
`endif
                end else if (wd == WD_LAST) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_ADD: begin
                issue     = 1'b1;
                issue_cmd = CMD_ADD;
`ifdef SCALAR_MUL_CONST_TIME_EN
                issue_dummy = ~cur_bit;
`endif
                state_nx  = S_WAIT_A;
            end
            default: state_nx = S_IDLE;
        endcase

        // abort overrides every other event once an operation is running.
        if (abort && state != S_IDLE) begin
            state_nx    = S_IDLE;
            idx_nx      = idx;
            issue       = 1'b0;
            finish_ok   = 1'b0;
            finish_zero = 1'b0;
            timeout     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= IDX_TOP;
            scalar_r <= '0;
            wd       <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (accept) scalar_r <= scalar;
            if (issue) begin
                wd <= '0;
            end else if (state == S_WAIT_A || state == S_WAIT_D) begin
                wd <= wd + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid          <= 1'b0;
            command_add_double <= 2'b00;
            op_count           <= 16'd0;
            done               <= 1'b0;
            zero_result        <= 1'b0;
            err                <= 1'b0;
        end else begin
            cmd_valid <= issue;
            done      <= finish_ok | finish_zero;
            if (issue) command_add_double <= issue_cmd;
            if (accept) begin
                op_count <= 16'd0;
            end else if (issue && op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
            if (accept) begin
                zero_result <= 1'b0;
            end else if (finish_zero) begin
                zero_result <= 1'b1;
            end
            if (accept) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end

`ifdef SCALAR_MUL_CONST_TIME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_dummy <= 1'b0;
            found     <= 1'b0;
            lead      <= '0;
        end else begin
            if (issue) add_dummy <= issue_dummy;
            found <= found_nx;
            lead  <= lead_nx;
        end
    end
`else
    assign add_dummy = 1'b0;
`endif

endmodule

// File: tb/tb_scalar_mul_sequencer.sv
`timescale 1ns/1ps
// Bench for scalar_mul_sequencer with a small key (16 bits) and a short
// watchdog (16 cycles) so full operations stay quick.
module tb_scalar_mul_sequencer;
    localparam int KEY_W       = 16;
    localparam int IDX_W       = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam logic [1:0] C_DBL  = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_LOAD = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [KEY_W-1:0] scalar = '0;
    logic             interupt_point_double = 1'b0;
    logic             interupt_point_addition = 1'b0;
    logic             cmd_valid;
    logic [1:0]       command_add_double;
    logic             add_dummy;
    logic             busy;
    logic             done;
    logic             zero_result;
    logic             err;
    logic [IDX_W-1:0] bit_index;
    logic [15:0]      op_count;

    int checks = 0;
    int errors = 0;
    // Expected command stream: {add_dummy, command}
    logic [2:0] exp_q[$];

    scalar_mul_sequencer #(
        .KEY_W(KEY_W), .IDX_W(IDX_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .scalar(scalar),
        .interupt_point_double(interupt_point_double),
        .interupt_point_addition(interupt_point_addition),
        .cmd_valid(cmd_valid), .command_add_double(command_add_double),
        .add_dummy(add_dummy), .busy(busy), .done(done),
        .zero_result(zero_result), .err(err), .bit_index(bit_index),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL global_time_limit: observed running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Double-and-add schedule from the key: LOAD for the top set bit, then for
    // every lower bit a DOUBLE followed by an ADD when that bit is set (always
    // an ADD in constant-time mode, dummy when the bit is clear).
    task automatic build_expected(input logic [KEY_W-1:0] k, output int msb);
        exp_q.delete();
        msb = -1;
        for (int i = 0; i < KEY_W; i++) if (k[i]) msb = i;
        if (msb >= 0) begin
            exp_q.push_back({1'b0, C_LOAD});
            for (int i = msb - 1; i >= 0; i--) begin
                exp_q.push_back({1'b0, C_DBL});
`ifdef SCALAR_MUL_CONST_TIME_EN
                exp_q.push_back({~k[i], C_ADD});
`else
                if (k[i]) exp_q.push_back({1'b0, C_ADD});
`endif
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'(0));
        check({tag, "_command"}, 32'(command_add_double), 32'(0));
        check({tag, "_add_dummy"}, 32'(add_dummy), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_zero_result"}, 32'(zero_result), 32'(0));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_bit_index"}, 32'(bit_index), 32'(KEY_W - 1));
        check({tag, "_op_count"}, 32'(op_count), 32'(0));
    endtask

    task automatic start_op(input logic [KEY_W-1:0] k, input bit with_abort);
        @(negedge clk);
        scalar = k;
        start  = 1'b1;
        abort  = with_abort;
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        scalar = KEY_W'($urandom);
    endtask

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            interupt_point_double   = 1'b0;
            interupt_point_addition = 1'b0;
            if (cmd_valid) ok = 1'b1;
        end
    endtask

    // Full operation driven by an interrupt-answering engine model.
    task automatic run_op(input logic [KEY_W-1:0] k, input int lat_lo, input int lat_hi,
                          input bit noise, input bit with_abort);
        int msb, cyc, first_cmd, lat, exp_cnt, exp_lat;
        bit pend, pend_dbl, got_done, busy_bad;
        logic [2:0] e;
        logic [1:0] last_cmd;
        build_expected(k, msb);
        exp_cnt = exp_q.size();
`ifdef SCALAR_MUL_CONST_TIME_EN
        exp_lat = KEY_W + 1;
`else
        exp_lat = KEY_W - msb + 1;
`endif
        start_op(k, with_abort);
        check("start_busy", 32'(busy), 32'(1));
        check("start_err_clr", 32'(err), 32'(0));
        check("start_zero_clr", 32'(zero_result), 32'(0));
        check("start_cnt_clr", 32'(op_count), 32'(0));
        cyc = 0; first_cmd = -1; lat = 0;
        pend = 1'b0; pend_dbl = 1'b0; got_done = 1'b0; busy_bad = 1'b0;
        last_cmd = 2'b00;
        while (!got_done && cyc < 3000) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (!busy) busy_bad = 1'b1;
                if (cmd_valid) begin
                    if (first_cmd < 0) first_cmd = cyc;
                    if (exp_q.size() == 0) begin
                        check("cmd_extra", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd", 32'({add_dummy, command_add_double}), 32'(e));
                        last_cmd = e[1:0];
                        pend     = 1'b1;
                        pend_dbl = (e[1:0] == C_DBL);
                        lat      = $urandom_range(lat_hi, lat_lo);
                    end
                end
                if (pend) begin
                    if (lat == 0) begin
                        if (pend_dbl) interupt_point_double = 1'b1;
                        else interupt_point_addition = 1'b1;
                        if (noise && $urandom_range(0, 2) == 0) begin
                            interupt_point_double   = 1'b1;
                            interupt_point_addition = 1'b1;
                        end
                        pend = 1'b0;
                    end else begin
                        lat--;
                        if (noise && $urandom_range(0, 3) == 0) begin
                            if (pend_dbl) interupt_point_addition = 1'b1;
                            else interupt_point_double = 1'b1;
                        end
                    end
                end else if (noise && $urandom_range(0, 3) == 0) begin
                    interupt_point_double   = 1'($urandom_range(0, 1));
                    interupt_point_addition = 1'($urandom_range(0, 1));
                end
                if (noise && busy && $urandom_range(0, 15) == 0) start = 1'b1;
                @(negedge clk);
                interupt_point_double   = 1'b0;
                interupt_point_addition = 1'b0;
                start = 1'b0;
                cyc++;
            end
        end
        check("done_seen", 32'(got_done), 32'(1));
        if (got_done) begin
            check("busy_during_op", 32'(busy_bad), 32'(0));
            check("busy_at_done", 32'(busy), 32'(0));
            check("op_count", 32'(op_count), 32'(exp_cnt));
            check("cmds_left", 32'(exp_q.size()), 32'(0));
            check("zero_result", 32'(zero_result), 32'(k == '0));
            check("err_at_done", 32'(err), 32'(0));
            check("bit_index_end", 32'(bit_index), 32'(0));
            if (exp_cnt > 0) begin
                check("first_cmd_latency", 32'(first_cmd), 32'(exp_lat));
                check("cmd_hold", 32'(command_add_double), 32'(last_cmd));
            end else begin
                check("zero_scan_len", 32'(cyc), 32'(KEY_W));
                check("zero_no_cmd", 32'(first_cmd), 32'(-1));
            end
            @(negedge clk);
            check("done_pulse_width", 32'(done), 32'(0));
        end
    endtask

    initial begin
        logic [KEY_W-1:0] k;
        bit ok, err_early, busy_early, seen_done, seen_cmd, busy_late;

        // Clock/reset
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: single LSB, 6, zero, latency boundaries
        run_op(KEY_W'(1), 0, 3, 1'b0, 1'b0);
        run_op(KEY_W'(6), 0, 3, 1'b0, 1'b0);
        run_op(KEY_W'(0), 0, 3, 1'b1, 1'b0);
        run_op(KEY_W'(4), 1, 2, 1'b0, 1'b0);
        run_op(KEY_W'(16'hA5), TIMEOUT_CYC - 1, TIMEOUT_CYC - 1, 1'b0, 1'b0);
        run_op(KEY_W'(16'h8001), 0, 0, 1'b1, 1'b0);

        // Watchdog: scalar=3, DOUBLE answer withheld
        start_op(KEY_W'(3), 1'b0);
        wait_cmd(ok);
        check("wd_load_seen", 32'(ok), 32'(1));
        check("wd_load_cmd", 32'(command_add_double), 32'(C_LOAD));
        interupt_point_addition = 1'b1;
        wait_cmd(ok);
        check("wd_dbl_seen", 32'(ok), 32'(1));
        check("wd_dbl_cmd", 32'(command_add_double), 32'(C_DBL));
        err_early = 1'b0; busy_early = 1'b0; seen_done = 1'b0;
        for (int i = 1; i <= TIMEOUT_CYC; i++) begin
            @(negedge clk);
            if (i < TIMEOUT_CYC && err) err_early = 1'b1;
            if (i < TIMEOUT_CYC && !busy) busy_early = 1'b1;
            if (done) seen_done = 1'b1;
        end
        check("wd_err_early", 32'(err_early), 32'(0));
        check("wd_busy_early", 32'(busy_early), 32'(0));
        check("wd_err", 32'(err), 32'(1));
        check("wd_busy", 32'(busy), 32'(0));
        check("wd_no_done", 32'(seen_done), 32'(0));

        // abort while IDLE: no effect, err stays sticky
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 32'(busy), 32'(0));
        check("err_sticky", 32'(err), 32'(1));
        run_op(KEY_W'($urandom_range(1, 65535)), 0, 6, 1'b0, 1'b0);

        // abort during the first WAIT_D, late interrupt 2 cycles later
        start_op(KEY_W'(5), 1'b0);
        wait_cmd(ok);
        check("ab_load_cmd", 32'(command_add_double), 32'(C_LOAD));
        interupt_point_addition = 1'b1;
        wait_cmd(ok);
        check("ab_dbl_cmd", 32'(command_add_double), 32'(C_DBL));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy_drop", 32'(busy), 32'(0));
        @(negedge clk);
        interupt_point_double = 1'b1;
        seen_done = 1'b0; seen_cmd = 1'b0; busy_late = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            interupt_point_double = 1'b0;
            if (done) seen_done = 1'b1;
            if (cmd_valid) seen_cmd = 1'b1;
            if (busy) busy_late = 1'b1;
        end
        check("ab_no_done", 32'(seen_done), 32'(0));
        check("ab_no_cmd", 32'(seen_cmd), 32'(0));
        check("ab_no_busy", 32'(busy_late), 32'(0));
        check("ab_op_count", 32'(op_count), 32'(2));
        check("ab_err", 32'(err), 32'(0));

        // start and abort together in IDLE: start wins
        run_op(KEY_W'($urandom_range(1, 65535)), 0, 5, 1'b0, 1'b1);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       k = KEY_W'($urandom);
                1:       k = KEY_W'($urandom_range(0, 15));
                2:       k = KEY_W'(1) << $urandom_range(0, KEY_W - 1);
                default: k = KEY_W'($urandom) & KEY_W'($urandom);
            endcase
            run_op(k, 0, 12, 1'b1, 1'b0);
        end
        run_op(KEY_W'(16'hFFFF), 0, 4, 1'b1, 1'b0);
        run_op(KEY_W'(16'h8000), 0, 4, 1'b1, 1'b0);

        // Async reset in the middle of an operation
        start_op(KEY_W'(6), 1'b0);
        wait_cmd(ok);
        check("rst_load_seen", 32'(ok), 32'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'(0));
        run_op(KEY_W'(16'h0B), 0, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
